// File: rtl/ddr3_mcb_cmd_ctl_fsm_if.sv
// Request and DDR3 command-bus bundle for the MCB command-sequencing FSM.
// master = requester / bus observer, slave = the command FSM.
interface ddr3_mcb_cmd_ctl_fsm_if #(
  parameter int ROW_W = 14,
  parameter int COL_W = 10,
  parameter int BA_W  = 3
) ();
  logic             req_valid;
  logic             req_we;
  logic [BA_W-1:0]  req_ba;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             req_ready;
  logic             cmd_cs_n;
  logic             cmd_ras_n;
  logic             cmd_cas_n;
  logic             cmd_we_n;
  logic [BA_W-1:0]  cmd_ba;
  logic [ROW_W-1:0] cmd_addr;
  logic             c_rd;
  logic             c_wr;
  logic             ref_busy;

  modport master (
    output req_valid, req_we, req_ba, req_row, req_col,
    input  req_ready, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n,
    input  cmd_ba, cmd_addr, c_rd, c_wr, ref_busy
  );

  modport slave (
    input  req_valid, req_we, req_ba, req_row, req_col,
    output req_ready, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n,
    output cmd_ba, cmd_addr, c_rd, c_wr, ref_busy
  );
endinterface

// File: rtl/ddr3_mcb_cmd_ctl_fsm.sv
// DDR3 MCB command sequencer: closed-page ACT -> RD/WR -> PRE per request,
// plus periodic auto-refresh; pulses c_rd/c_wr to the data-control FSM.
module ddr3_mcb_cmd_ctl_fsm #(
  parameter int ROW_W    = 14,
  parameter int COL_W    = 10,
  parameter int BA_W     = 3,
  parameter int T_RCD    = 6,
  parameter int T_RD2PRE = 4,
  parameter int T_WR2PRE = 14,
  parameter int T_RP     = 6,
  parameter int T_RFC    = 64,
  parameter int T_REFI   = 3120
) (
  input  logic                 ddr3_mcb_clk,
  input  logic                 ddr3_mcb_rst_n,
  input  logic                 init_done,
  ddr3_mcb_cmd_ctl_fsm_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_RCD, T_RD2PRE), max2(T_WR2PRE, T_RP)), T_RFC);
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int RW    = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  localparam logic [TW-1:0] LD_RCD    = TW'(T_RCD - 2);
  localparam logic [TW-1:0] LD_RD2PRE = TW'(T_RD2PRE - 2);
  localparam logic [TW-1:0] LD_WR2PRE = TW'(T_WR2PRE - 2);
  localparam logic [TW-1:0] LD_RP     = TW'(T_RP - 2);
  localparam logic [TW-1:0] LD_RFC    = TW'(T_RFC - 2);
  localparam logic [RW-1:0] REFI_LAST = RW'(T_REFI - 1);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DES = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [3:0] {
    IDLE, ACT, TRCD, RDWR, T2PRE, PRE, TRP, REF, TRFC
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    t_cnt_q, t_cnt_d;
  logic [RW-1:0]    ref_cnt_q;
  logic             ref_pend_q;
  logic             we_q;
  logic [BA_W-1:0]  ba_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  logic             capture;
  logic [3:0]       cmd;
  logic [ROW_W-1:0] addr;
  logic [BA_W-1:0]  ba;
  logic             rd_pulse, wr_pulse, busy_ref, ready;

  always_comb begin
    state_d  = state_q;
    t_cnt_d  = t_cnt_q;
    capture  = 1'b0;
    cmd      = CMD_NOP;
    addr     = '0;
    ba       = '0;
    rd_pulse = 1'b0;
    wr_pulse = 1'b0;
    busy_ref = 1'b0;
    ready    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd   = CMD_DES;
        ready = init_done & ~ref_pend_q;
        // Refresh takes priority; ready is already low whenever it is pending.
        if (init_done && ref_pend_q) begin
          state_d = REF;
        end else if (bus.req_valid && ready) begin
          capture = 1'b1;
          state_d = ACT;
        end
      end
      ACT: begin
        cmd     = CMD_ACT;
        addr    = row_q;
        ba      = ba_q;
        t_cnt_d = LD_RCD;
        state_d = TRCD;
      end
      TRCD: begin
        if (t_cnt_q == '0) state_d = RDWR;
        else               t_cnt_d = t_cnt_q - 1'b1;
      end
      RDWR: begin
        cmd      = we_q ? CMD_WR : CMD_RD;
        addr     = ROW_W'(col_q);
        ba       = ba_q;
        rd_pulse = ~we_q;
        wr_pulse = we_q;
        t_cnt_d  = we_q ? LD_WR2PRE : LD_RD2PRE;
        state_d  = T2PRE;
      end
      T2PRE: begin
        if (t_cnt_q == '0) state_d = PRE;
        else               t_cnt_d = t_cnt_q - 1'b1;
      end
      PRE: begin
        cmd     = CMD_PRE;
        ba      = ba_q;
        t_cnt_d = LD_RP;
        state_d = TRP;
      end
      TRP: begin
        if (t_cnt_q == '0) state_d = IDLE;
        else               t_cnt_d = t_cnt_q - 1'b1;
      end
      REF: begin
        cmd      = CMD_REF;
        busy_ref = 1'b1;
        t_cnt_d  = LD_RFC;
        state_d  = TRFC;
      end
      TRFC: begin
        busy_ref = 1'b1;
        if (t_cnt_q == '0) state_d = IDLE;
        else               t_cnt_d = t_cnt_q - 1'b1;
      end
      default: begin
        cmd     = CMD_DES;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ddr3_mcb_clk) begin
    if (!ddr3_mcb_rst_n) begin
      state_q <= IDLE;
      t_cnt_q <= '0;
      we_q    <= 1'b0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      t_cnt_q <= t_cnt_d;
      if (capture) begin
        we_q  <= bus.req_we;
        ba_q  <= bus.req_ba;
        row_q <= bus.req_row;
        col_q <= bus.req_col;
      end
    end
  end

  // Refresh timer runs independently of the FSM; a wrap during REF re-arms it.
  always_ff @(posedge ddr3_mcb_clk) begin
    if (!ddr3_mcb_rst_n) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      if (!init_done || ref_cnt_q == REFI_LAST) ref_cnt_q <= '0;
      else                                      ref_cnt_q <= ref_cnt_q + 1'b1;
      if (init_done && ref_cnt_q == REFI_LAST) ref_pend_q <= 1'b1;
      else if (state_q == REF)                 ref_pend_q <= 1'b0;
    end
  end

  assign bus.cmd_cs_n  = cmd[3];
  assign bus.cmd_ras_n = cmd[2];
  assign bus.cmd_cas_n = cmd[1];
  assign bus.cmd_we_n  = cmd[0];
  assign bus.cmd_addr  = addr;
  assign bus.cmd_ba    = ba;
  assign bus.c_rd      = rd_pulse;
  assign bus.c_wr      = wr_pulse;
  assign bus.ref_busy  = busy_ref;
  assign bus.req_ready = ready;

endmodule

// File: tb/tb_ddr3_mcb_cmd_ctl_fsm.sv
// Bench for ddr3_mcb_cmd_ctl_fsm: directed timeline checks plus random traffic
// compared each cycle against a schedule-based reference model.
module tb_ddr3_mcb_cmd_ctl_fsm;
  localparam int ROW_W    = 14;
  localparam int COL_W    = 10;
  localparam int BA_W     = 3;
  localparam int T_RCD    = 6;
  localparam int T_RD2PRE = 4;
  localparam int T_WR2PRE = 14;
  localparam int T_RP     = 6;
  localparam int T_RFC    = 64;
  localparam int T_REFI   = 3120;

  localparam logic [3:0] C_DES = 4'hF;
  localparam logic [3:0] C_NOP = 4'h7;
  localparam logic [3:0] C_ACT = 4'h3;
  localparam logic [3:0] C_RD  = 4'h5;
  localparam logic [3:0] C_WR  = 4'h4;
  localparam logic [3:0] C_PRE = 4'h2;
  localparam logic [3:0] C_REF = 4'h1;

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;
  always #5 clk = ~clk;

  ddr3_mcb_cmd_ctl_fsm_if #(.ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W)) bus ();

  ddr3_mcb_cmd_ctl_fsm #(
    .ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W), .T_RCD(T_RCD), .T_RD2PRE(T_RD2PRE),
    .T_WR2PRE(T_WR2PRE), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI)
  ) dut (
    .ddr3_mcb_clk  (clk),
    .ddr3_mcb_rst_n(rst_n),
    .init_done     (init_done),
    .bus           (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int obs_acc = -1;
  logic [24:0] obs_hist [int];

  // Reference model: expected commands scheduled by absolute cycle number.
  bit               m_known = 0;
  int               m_free_at = 0;
  int               m_busy_lo = 0;
  int               m_busy_hi = -1;
  int               m_ref_cnt = 0;
  bit               m_pend = 0;
  int               m_clear_at = -1;
  logic [3:0]       s_cmd  [int];
  logic [ROW_W-1:0] s_addr [int];
  logic [BA_W-1:0]  s_ba   [int];
  bit               s_crd  [int];
  bit               s_cwr  [int];

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  function automatic logic [24:0] hist(input int k);
    return obs_hist.exists(k) ? obs_hist[k] : '1;
  endfunction
  function automatic int f_cmd(input int k);
    logic [24:0] v; v = hist(k); return int'(v[24:21]);
  endfunction
  function automatic int f_addr(input int k);
    logic [24:0] v; v = hist(k); return int'(v[20:7]);
  endfunction
  function automatic int f_ba(input int k);
    logic [24:0] v; v = hist(k); return int'(v[6:4]);
  endfunction
  function automatic int f_bit(input int k, input int pos);
    logic [24:0] v; v = hist(k); return int'(v[pos]);
  endfunction
  function automatic int count_bit(input int lo, input int hi, input int pos);
    int n = 0;
    for (int k = lo; k <= hi; k++) n += f_bit(k, pos);
    return n;
  endfunction
  function automatic int count_non_des(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (f_cmd(k) != int'(C_DES)) n++;
    return n;
  endfunction

  task automatic drive_req(input logic v, input logic we, input logic [BA_W-1:0] b,
                           input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_ba    = b;
    bus.req_row   = r;
    bus.req_col   = c;
  endtask

  task automatic tick();
    logic [24:0]      obs, expv;
    logic [3:0]       e_cmd;
    logic [ROW_W-1:0] e_addr;
    logic [BA_W-1:0]  e_ba;
    logic             e_crd, e_cwr, e_busy, e_rdy;
    bit               idle, wrap;
    int               t, a, r, p;
    #1;
    t   = cyc;
    obs = {bus.cmd_cs_n, bus.cmd_ras_n, bus.cmd_cas_n, bus.cmd_we_n, bus.cmd_addr,
           bus.cmd_ba, bus.c_rd, bus.c_wr, bus.ref_busy, bus.req_ready};
    obs_hist[t] = obs;
    if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) obs_acc = t;

    idle   = (t >= m_free_at);
    e_cmd  = s_cmd.exists(t) ? s_cmd[t] : (idle ? C_DES : C_NOP);
    e_addr = s_addr.exists(t) ? s_addr[t] : '0;
    e_ba   = s_ba.exists(t) ? s_ba[t] : '0;
    e_crd  = s_crd.exists(t);
    e_cwr  = s_cwr.exists(t);
    e_busy = (t >= m_busy_lo) && (t <= m_busy_hi);
    e_rdy  = idle && init_done && !m_pend;
    expv   = {e_cmd, e_addr, e_ba, e_crd, e_cwr, e_busy, e_rdy};
    if (m_known) begin
      checks++;
      assert (obs === expv) else begin
        errors++;
        $error("FAIL cycle_%0d bus {cmd,addr,ba,c_rd,c_wr,ref_busy,req_ready}: observed %h expected %h",
               t, obs, expv);
      end
    end

    if (!rst_n) begin
      m_known = 1; m_free_at = t + 1;
      s_cmd.delete(); s_addr.delete(); s_ba.delete(); s_crd.delete(); s_cwr.delete();
      m_busy_lo = 0; m_busy_hi = -1;
      m_ref_cnt = 0; m_pend = 0; m_clear_at = -1;
    end else begin
      if (idle && init_done && m_pend) begin
        s_cmd[t+1] = C_REF;
        m_busy_lo  = t + 1;
        m_busy_hi  = t + T_RFC;
        m_free_at  = t + 1 + T_RFC;
        m_clear_at = t + 1;
      end else if (e_rdy && bus.req_valid) begin
        a = t + 1;
        r = a + T_RCD;
        p = r + (bus.req_we ? T_WR2PRE : T_RD2PRE);
        s_cmd[a] = C_ACT; s_addr[a] = bus.req_row; s_ba[a] = bus.req_ba;
        s_cmd[r] = bus.req_we ? C_WR : C_RD;
        s_addr[r] = ROW_W'(bus.req_col); s_ba[r] = bus.req_ba;
        if (bus.req_we) s_cwr[r] = 1'b1; else s_crd[r] = 1'b1;
        s_cmd[p] = C_PRE; s_addr[p] = '0; s_ba[p] = bus.req_ba;
        m_free_at = p + T_RP;
      end
      wrap = init_done && (m_ref_cnt == T_REFI - 1);
      if (!init_done || wrap) m_ref_cnt = 0; else m_ref_cnt++;
      if (wrap) m_pend = 1;
      else if (t == m_clear_at) m_pend = 0;
    end

    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    int ta, c0, rs, w0, off;
    rst_n = 1'b0;
    init_done = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    chk("reset_cmd", f_cmd(cyc-1), C_DES);
    chk("reset_addr_ba", f_addr(cyc-1) + f_ba(cyc-1), 0);
    chk("reset_ready", f_bit(cyc-1, 0), 0);

    // Directed read
    rst_n = 1'b1; init_done = 1'b1;
    drive_req(1'b1, 1'b0, 3'd5, 14'h1234, 10'h0A8);
    ta = cyc;
    tick();
    bus.req_valid = 1'b0;
    repeat (20) tick();
    chk("rd_accept", obs_acc, ta);
    chk("rd_act_cmd", f_cmd(ta+1), C_ACT);
    chk("rd_act_addr", f_addr(ta+1), 'h1234);
    chk("rd_act_ba", f_ba(ta+1), 5);
    chk("rd_cmd", f_cmd(ta+7), C_RD);
    chk("rd_addr", f_addr(ta+7), 'h00A8);
    chk("rd_pulse", count_bit(ta+6, ta+8, 3), 1);
    chk("rd_pulse_at7", f_bit(ta+7, 3), 1);
    chk("rd_pre", f_cmd(ta+11), C_PRE);
    chk("rd_ready_16", f_bit(ta+16, 0), 0);
    chk("rd_ready_17", f_bit(ta+17, 0), 1);
    chk("rd_no_cwr", count_bit(ta, ta+20, 2), 0);

    // Directed write
    drive_req(1'b1, 1'b1, 3'($urandom_range(0, 7)), 14'($urandom), 10'($urandom));
    ta = cyc;
    tick();
    bus.req_valid = 1'b0;
    repeat (30) tick();
    chk("wr_act", f_cmd(ta+1), C_ACT);
    chk("wr_cmd", f_cmd(ta+7), C_WR);
    chk("wr_pulse", count_bit(ta, ta+30, 2), 1);
    chk("wr_pulse_at7", f_bit(ta+7, 2), 1);
    chk("wr_pre_20", f_cmd(ta+20), C_NOP);
    chk("wr_pre", f_cmd(ta+21), C_PRE);
    chk("wr_ready_26", f_bit(ta+26, 0), 0);
    chk("wr_ready_27", f_bit(ta+27, 0), 1);
    chk("wr_no_crd", count_bit(ta, ta+30, 3), 0);

    // Refresh timing from init_done rise; second expiry collides with a request
    rst_n = 1'b0; init_done = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1; init_done = 1'b1;
    c0 = cyc;
    while (cyc < c0 + 6330) begin
      if (cyc == c0 + 6240)
        drive_req(1'b1, 1'b0, 3'($urandom_range(0, 7)), 14'($urandom), 10'($urandom));
      tick();
      if (obs_acc == cyc - 1) bus.req_valid = 1'b0;
    end
    chk("ref_ready_3119", f_bit(c0+3119, 0), 1);
    chk("ref_ready_3120", f_bit(c0+3120, 0), 0);
    chk("ref_cmd_3120", f_cmd(c0+3120), C_DES);
    chk("ref_cmd_3121", f_cmd(c0+3121), C_REF);
    chk("ref_busy_len", count_bit(c0+3110, c0+3200, 1), 64);
    chk("ref_busy_last", f_bit(c0+3184, 1), 1);
    chk("ref_ready_3184", f_bit(c0+3184, 0), 0);
    chk("ref_ready_3185", f_bit(c0+3185, 0), 1);
    chk("ref2_ready_6240", f_bit(c0+6240, 0), 0);
    chk("ref2_cmd", f_cmd(c0+6241), C_REF);
    chk("ref2_act", f_cmd(c0+6241+T_RFC+1), C_ACT);
    chk("ref2_accept", obs_acc, c0+6241+T_RFC);

    // Reset while in TRCD
    drive_req(1'b1, 1'b0, 3'($urandom_range(0, 7)), 14'($urandom), 10'($urandom));
    ta = cyc;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rs = cyc;
    while (cyc < rs + 3200) tick();
    chk("rst_act_seen", f_cmd(ta+1), C_ACT);
    chk("rst_des", f_cmd(rs), C_DES);
    chk("rst_no_pulse", count_bit(rs-1, rs+20, 3) + count_bit(rs-1, rs+20, 2), 0);
    chk("rst_no_pre", count_non_des(rs, rs+20), 0);
    chk("rst_ready", f_bit(rs, 0), 1);
    chk("rst_refcnt_ready", f_bit(rs+3119, 0), 1);
    chk("rst_refcnt_ref", f_cmd(rs+3121), C_REF);

    // init_done low with a request waiting
    init_done = 1'b0;
    w0 = cyc;
    for (int i = 0; i < 100; i++) begin
      drive_req(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 14'($urandom), 10'($urandom));
      tick();
    end
    chk("noinit_cmds", count_non_des(w0, w0+99), 0);
    chk("noinit_ready", count_bit(w0, w0+99, 0), 0);

    // Random traffic with occasional init_done drops early on
    bus.req_valid = 1'b0;
    init_done = 1'b1;
    off = 0;
    for (int i = 0; i < 5000; i++) begin
      if (i < 1000 && off == 0 && $urandom_range(0, 299) == 0) off = $urandom_range(1, 5);
      init_done = (off == 0);
      if (off > 0) off--;
      drive_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 14'($urandom), 10'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
